// File: rtl/pio_out_blink_if.sv
// Avalon-MM slave bus bundle for the pio_out_blink output port block.
// The master drives address/strobe/data; the slave returns combinational readdata.
interface pio_out_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pio_out_blink.sv
// Parametrised Avalon-MM output PIO with atomic set/clear/toggle, per-bit
// hardware blink driven by a programmable half-period, and a status register.
// Zero-wait-state slave: writes commit on the rising edge, readdata is
// combinational from address and current register state.
module pio_out_blink #(
   parameter int                 WIDTH        = 18,
   parameter logic [WIDTH-1:0]   RESET_VALUE  = '0,
   parameter int                 PERIOD_W     = 24,
   parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(2499999)
) (
   input  logic                  clk,
   input  logic                  reset,
   pio_out_blink_if.slave        bus,
   output logic [WIDTH-1:0]      out_port
);

   // Register map word addresses
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLEAR  = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE = 3'd3;
   localparam logic [2:0] ADDR_MASK   = 3'd4;
   localparam logic [2:0] ADDR_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   logic [WIDTH-1:0]    data_q,   data_d;
   logic [WIDTH-1:0]    mask_q,   mask_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q,    cnt_d;
   logic                phase_q,  phase_d;

   logic                wr_en;
   logic [WIDTH-1:0]    wd_bits;
   logic [PERIOD_W-1:0] wd_period;
   logic                mask_any;
   logic                period_wr;
   logic                mask_wr_zero;
   logic [31:0]         rd_data;

   // Bits of writedata beyond WIDTH/PERIOD_W are intentionally ignored.
   wire unused_wd = &{1'b0, bus.writedata};

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign wd_bits      = bus.writedata[WIDTH-1:0];
   assign wd_period    = bus.writedata[PERIOD_W-1:0];
   assign mask_any     = |mask_q;
   assign period_wr    = wr_en && (bus.address == ADDR_PERIOD);
   assign mask_wr_zero = wr_en && (bus.address == ADDR_MASK) && (wd_bits == '0);

   // Register writes: DATA updates are read-modify-write against the current
   // value so set/clear/toggle are atomic from the CPU's point of view.
   always_comb begin
      data_d   = data_q;
      mask_d   = mask_q;
      period_d = period_q;
      if (wr_en) begin
         case (bus.address)
            ADDR_DATA:   data_d   = wd_bits;
            ADDR_SET:    data_d   = data_q | wd_bits;
            ADDR_CLEAR:  data_d   = data_q & ~wd_bits;
            ADDR_TOGGLE: data_d   = data_q ^ wd_bits;
            ADDR_MASK:   mask_d   = wd_bits;
            ADDR_PERIOD: period_d = wd_period;
            default:     ;
         endcase
      end
   end

   // Blink engine: a PERIOD write restarts the count without touching phase,
   // clearing MASK parks the engine, otherwise count and toggle on wrap.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (period_wr) begin
         cnt_d = '0;
      end else if (mask_wr_zero || !mask_any) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == period_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   // State registers with asynchronous reset to the documented reset values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q   <= RESET_VALUE;
         mask_q   <= '0;
         period_q <= PERIOD_RESET;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         data_q   <= data_d;
         mask_q   <= mask_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   // Each pin is its data bit, inverted while that bit is masked and phase is high.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
         assign out_port[gi] = data_q[gi] ^ (mask_q[gi] & phase_q);
      end
   endgenerate

   // Combinational read mux; unused upper bits and write-only registers read 0.
   always_comb begin
      rd_data = '0;
      case (bus.address)
         ADDR_DATA:   rd_data[WIDTH-1:0]    = data_q;
         ADDR_SET:    rd_data[WIDTH-1:0]    = out_port;
         ADDR_MASK:   rd_data[WIDTH-1:0]    = mask_q;
         ADDR_PERIOD: rd_data[PERIOD_W-1:0] = period_q;
         ADDR_STATUS: rd_data[1:0]          = {mask_any, phase_q};
         default:     ;
      endcase
   end

   assign bus.readdata = rd_data;

endmodule

// File: tb/tb_pio_out_blink.sv
// Scoreboard bench for pio_out_blink: stimulus pushes expected pin/readdata
// values per cycle, a negedge monitor pops and compares them.
module tb_pio_out_blink;

   localparam int          WIDTH = 18;
   localparam logic [17:0] RV    = 18'h2A5A5;

   logic        clk;
   logic        reset;
   logic [17:0] port_w;

   pio_out_blink_if bus_if ();

   pio_out_blink #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RV),
      .PERIOD_W    (24)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if.slave),
      .out_port (port_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_rd;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb[$];
   int checks   = 0;
   int failures = 0;

   task automatic push(input string n, input bit r, input logic [31:0] e);
      sb_item_t it;
      it.name  = n;
      it.is_rd = r;
      it.exp   = e;
      sb.push_back(it);
   endtask

   // One bus cycle: drive just after the edge, queue what should be visible now.
   task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                       input bit cp, input logic [31:0] ep,
                       input bit cr, input logic [31:0] er, input string n);
      @(posedge clk);
      #1;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = ~wr;
      bus_if.address    = a;
      bus_if.writedata  = wd;
      if (cp) push({n, "_port"}, 1'b0, ep);
      if (cr) push({n, "_rd"}, 1'b1, er);
   endtask

   // Monitor: compare every queued expectation at the falling edge.
   initial begin
      sb_item_t    it;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            it  = sb.pop_front();
            act = it.is_rd ? bus_if.readdata : 32'(port_w);
            checks++;
            if (act !== it.exp) begin
               failures++;
               $display("FAIL %s actual=%h required=%h", it.name, act, it.exp);
            end else begin
               $display("ok   %s value=%h", it.name, act);
            end
         end
      end
   end

   initial begin
      logic [31:0] ph;
      reset             = 1'b1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.address    = 3'd0;
      bus_if.writedata  = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      step(0, 3'd0, 0, 1, 32'h2A5A5, 1, 32'h2A5A5, "rst_data");
      step(0, 3'd6, 0, 1, 32'h2A5A5, 1, 32'h0,     "rst_status");
      step(0, 3'd4, 0, 0, 0,         1, 32'h0,     "rst_mask");
      step(0, 3'd5, 0, 0, 0,         1, 32'h2625_9F, "rst_period");

      // Atomic DATA operations
      step(1, 3'd0, 32'h00F0F, 1, 32'h2A5A5, 0, 0, "wr_data");
      step(1, 3'd1, 32'h30000, 1, 32'h00F0F, 0, 0, "wr_set");
      step(1, 3'd2, 32'h0000F, 1, 32'h30F0F, 0, 0, "wr_clear");
      step(1, 3'd3, 32'h00101, 1, 32'h30F00, 0, 0, "wr_toggle");
      step(0, 3'd1, 0, 1, 32'h30E01, 1, 32'h30E01, "rd_set");
      step(0, 3'd0, 0, 0, 0,         1, 32'h30E01, "rd_data");
      step(0, 3'd2, 0, 0, 0,         1, 32'h0,     "rd_clear");
      step(0, 3'd3, 0, 0, 0,         1, 32'h0,     "rd_toggle");

      // Reserved / ignored writes
      step(1, 3'd7, 32'hFFFF_FFFF, 1, 32'h30E01, 1, 32'h0, "wr_rsv");
      step(1, 3'd1, 32'hFFFC_0000, 1, 32'h30E01, 0, 0,     "wr_set_hi");
      step(1, 3'd6, 32'h3,         1, 32'h30E01, 0, 0,     "wr_status");
      step(0, 3'd0, 0, 1, 32'h30E01, 1, 32'h30E01, "after_ign");
      step(0, 3'd6, 0, 0, 0,         1, 32'h0,     "status_ign");
      step(0, 3'd7, 0, 0, 0,         1, 32'h0,     "rd_rsv");

      // Blink with PERIOD=3, MASK=3, DATA=0
      step(1, 3'd5, 32'd3, 1, 32'h30E01, 0, 0, "wr_period3");
      step(1, 3'd4, 32'd3, 1, 32'h30E01, 0, 0, "wr_mask3");
      step(1, 3'd0, 32'd0, 1, 32'h30E01, 1, 32'h30E01, "wr_data0");
      for (int k = 1; k <= 9; k++) begin
         ph = 32'((k / 4) & 1);
         step(0, 3'd6, 0, 1, (ph != 0) ? 32'h3 : 32'h0, 1, 32'h2 | ph, "blink_p3");
      end
      // cnt is 2 here: shorten PERIOD to 1
      step(1, 3'd5, 32'd1, 1, 32'h0, 0, 0, "wr_period1");
      for (int k = 11; k <= 16; k++) begin
         ph = 32'(((k - 11) / 2) & 1);
         step(0, 3'd6, 0, 1, (ph != 0) ? 32'h3 : 32'h0, 1, 32'h2 | ph, "blink_p1");
      end
      // phase is 1 here: clear MASK
      step(1, 3'd4, 32'd0, 1, 32'h3, 0, 0, "wr_mask0");
      step(0, 3'd6, 0, 1, 32'h0, 1, 32'h0, "mask0");
      step(1, 3'd4, 32'd1, 1, 32'h0, 0, 0, "wr_mask1");
      for (int k = 20; k <= 22; k++) begin
         ph = 32'(((k - 20) / 2) & 1);
         step(0, 3'd6, 0, 1, ph, 1, 32'h2 | ph, "blink_m1");
      end

      // Asynchronous reset mid-cycle while blinking (phase=1)
      @(posedge clk);
      #1;
      reset             = 1'b1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.address    = 3'd0;
      push("async_rst_port", 1'b0, 32'h2A5A5);
      push("async_rst_rd", 1'b1, 32'h2A5A5);
      step(0, 3'd4, 0, 1, 32'h2A5A5, 1, 32'h0, "rst_hold_mask");
      step(0, 3'd6, 0, 0, 0,         1, 32'h0, "rst_hold_status");
      reset = 1'b0;
      step(0, 3'd5, 0, 1, 32'h2A5A5, 1, 32'h2625_9F, "post_rst_period");
      step(0, 3'd6, 0, 1, 32'h2A5A5, 1, 32'h0,       "post_rst_status");

      // Let the monitor drain; anything left is a failure.
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
